// File: rtl/pf_iod_eye_train_ctrl_pkg.sv
// Shared types and defaults for the multi-lane IOD eye-training sequencer.
package pf_iod_train_pkg;

   localparam int unsigned DEF_SETTLE_CYCLES = 8;
   localparam int unsigned DEF_MAX_STEPS     = 127;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CLEAR,
      ST_SETTLE,
      ST_SAMPLE,
      ST_SETUP,
      ST_STEP,
      ST_NEXT,
      ST_DONE
   } train_state_e;

   typedef enum logic [1:0] {
      VOTE_NONE,
      VOTE_INC,
      VOTE_DEC
   } vote_e;

   // Early-only asks for more delay, late-only for less; both flags repeat the last vote (INC if none yet).
   function automatic vote_e vote_from_flags(input logic early, input logic late, input vote_e prev);
      vote_e v;
      v = VOTE_INC;
      if (early && !late) begin
         v = VOTE_INC;
      end else if (late && !early) begin
         v = VOTE_DEC;
      end else if (prev != VOTE_NONE) begin
         v = prev;
      end
      return v;
   endfunction

endpackage

// File: rtl/pf_iod_eye_train_ctrl_if.sv
// Per-lane IOD delay-line / eye-monitor bus between the training sequencer (master) and the IOD lanes (slave).
interface pf_iod_eye_train_ctrl_if #(
   parameter int unsigned NUM_LANES = 8
);
   logic [NUM_LANES-1:0] EYE_MONITOR_EARLY;
   logic [NUM_LANES-1:0] EYE_MONITOR_LATE;
   logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE;
   logic [NUM_LANES-1:0] EYE_MONITOR_CLEAR_FLAGS;
   logic [NUM_LANES-1:0] DELAY_LINE_LOAD;
   logic [NUM_LANES-1:0] DELAY_LINE_MOVE;
   logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION;

   modport master (
      input  EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
      output EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION
   );

   modport slave (
      output EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
      input  EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION
   );
endinterface

// File: rtl/pf_iod_eye_train_ctrl_lane_demux.sv
// Steers the sequencer's scalar strobes onto the selected lane and muxes that lane's flags back.
module pf_iod_lane_demux #(
   parameter int unsigned NUM_LANES = 8,
   parameter int unsigned LANE_W    = 3
) (
   input  logic [LANE_W-1:0]    out_sel_i,
   input  logic                 load_i,
   input  logic                 clear_i,
   input  logic                 move_i,
   input  logic                 dir_i,
   output logic [NUM_LANES-1:0] load_oh_c,
   output logic [NUM_LANES-1:0] clear_oh_c,
   output logic [NUM_LANES-1:0] move_oh_c,
   output logic [NUM_LANES-1:0] dir_oh_c,
   input  logic [LANE_W-1:0]    in_sel_i,
   input  logic [NUM_LANES-1:0] early_i,
   input  logic [NUM_LANES-1:0] late_i,
   input  logic [NUM_LANES-1:0] oor_i,
   output logic                 early_c,
   output logic                 late_c,
   output logic                 oor_c
);

   // One-hot steering: non-selected lanes see all zeros, including DIRECTION.
   always_comb begin
      load_oh_c  = '0;
      clear_oh_c = '0;
      move_oh_c  = '0;
      dir_oh_c   = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         if (out_sel_i == LANE_W'(i)) begin
            load_oh_c[i]  = load_i;
            clear_oh_c[i] = clear_i;
            move_oh_c[i]  = move_i;
            dir_oh_c[i]   = dir_i;
         end
      end
   end

   // Return path: flags of the lane currently being trained.
   always_comb begin
      early_c = 1'b0;
      late_c  = 1'b0;
      oor_c   = 1'b0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         if (in_sel_i == LANE_W'(i)) begin
            early_c = early_i[i];
            late_c  = late_i[i];
            oor_c   = oor_i[i];
         end
      end
   end

endmodule

// File: rtl/pf_iod_eye_train_ctrl.sv
// Multi-lane IOD eye-centring sequencer: trains lanes 0..NUM_LANES-1 in turn from sticky EARLY/LATE flags.
// Optional macro IOD_TRAIN_TAP_READBACK_EN adds TAP_POS with the final signed step count of every lane.
module pf_iod_eye_train_ctrl
   import pf_iod_train_pkg::*;
#(
   parameter int unsigned NUM_LANES     = 8,
   parameter int unsigned TAP_W         = 8,
   parameter int unsigned MAX_STEPS     = DEF_MAX_STEPS,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned CNT_W         = 4
) (
   input  logic                       FAB_CLK,
   input  logic                       SYNC_RST_N,
   input  logic                       TRAIN_START,
   output logic                       TRAIN_BUSY,
   output logic                       TRAIN_DONE,
   output logic [NUM_LANES-1:0]       LANE_LOCKED,
   output logic [NUM_LANES-1:0]       LANE_ERR,
`ifdef IOD_TRAIN_TAP_READBACK_EN
   output logic [NUM_LANES*TAP_W-1:0] TAP_POS,
`endif
   pf_iod_eye_train_ctrl_if.master    iod
);

   localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   train_state_e             state_q, state_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic signed [TAP_W-1:0]  step_q, step_d;
   vote_e                    vote_q, vote_d, new_vote;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NUM_LANES-1:0]     locked_q, locked_d, err_q, err_d;
   logic                     busy_q, done_q;
   logic [NUM_LANES-1:0]     load_q, clear_q, move_q, dir_q;
   logic [NUM_LANES-1:0]     load_oh_c, clear_oh_c, move_oh_c, dir_oh_c, lane_oh_c;
   logic                     early_c, late_c, oor_c;
   logic [TAP_W-1:0]         step_abs_c;

   // Strobes are steered by the next lane/state so the registered outputs line up with the state.
   pf_iod_lane_demux #(
      .NUM_LANES (NUM_LANES),
      .LANE_W    (LANE_W)
   ) u_demux (
      .out_sel_i  (lane_d),
      .load_i     (state_d == ST_LOAD),
      .clear_i    (state_d == ST_CLEAR),
      .move_i     (state_d == ST_STEP),
      .dir_i      (((state_d == ST_SETUP) || (state_d == ST_STEP)) && (vote_d == VOTE_INC)),
      .load_oh_c  (load_oh_c),
      .clear_oh_c (clear_oh_c),
      .move_oh_c  (move_oh_c),
      .dir_oh_c   (dir_oh_c),
      .in_sel_i   (lane_q),
      .early_i    (iod.EYE_MONITOR_EARLY),
      .late_i     (iod.EYE_MONITOR_LATE),
      .oor_i      (iod.DELAY_LINE_OUT_OF_RANGE),
      .early_c    (early_c),
      .late_c     (late_c),
      .oor_c      (oor_c)
   );

   // Active-lane one-hot for flag updates and magnitude of the signed step count.
   always_comb begin
      lane_oh_c = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         lane_oh_c[i] = (lane_q == LANE_W'(i));
      end
      step_abs_c = step_q[TAP_W-1] ? TAP_W'(-step_q) : TAP_W'(step_q);
   end

   // Sequencer next-state: load, clear/settle/sample loop, per-lane verdict, lane advance.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      step_d   = step_q;
      vote_d   = vote_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      err_d    = err_q;
      new_vote = vote_from_flags(early_c, late_c, vote_q);
      case (state_q)
         ST_IDLE: begin
            if (TRAIN_START) begin
               state_d  = ST_LOAD;
               lane_d   = '0;
               locked_d = '0;
               err_d    = '0;
            end
         end
         ST_LOAD: begin
            step_d  = '0;
            vote_d  = VOTE_NONE;
            state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (oor_c) begin
               err_d   = err_q | lane_oh_c;
               state_d = ST_NEXT;
            end else if (!early_c && !late_c) begin
               locked_d = locked_q | lane_oh_c;
               state_d  = ST_NEXT;
            end else if ((vote_q != VOTE_NONE) && (new_vote != vote_q)) begin
               // Vote flipped: the eye edge lies between this tap and the last one.
               locked_d = locked_q | lane_oh_c;
               state_d  = ST_NEXT;
            end else if (step_abs_c == TAP_W'(MAX_STEPS)) begin
               err_d   = err_q | lane_oh_c;
               state_d = ST_NEXT;
            end else begin
               vote_d  = new_vote;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_STEP;
         end
         ST_STEP: begin
            step_d  = (vote_q == VOTE_INC) ? step_q + TAP_W'(1) : step_q - TAP_W'(1);
            state_d = ST_CLEAR;
         end
         ST_NEXT: begin
            if (lane_q == LANE_W'(NUM_LANES - 1)) begin
               state_d = ST_DONE;
            end else begin
               lane_d  = lane_q + LANE_W'(1);
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, flags and registered lane strobes.
   always_ff @(posedge FAB_CLK) begin
      if (!SYNC_RST_N) begin
         state_q  <= ST_IDLE;
         lane_q   <= '0;
         step_q   <= '0;
         vote_q   <= VOTE_NONE;
         cnt_q    <= '0;
         locked_q <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         load_q   <= '0;
         clear_q  <= '0;
         move_q   <= '0;
         dir_q    <= '0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         step_q   <= step_d;
         vote_q   <= vote_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q   <= (state_d == ST_DONE);
         load_q   <= load_oh_c;
         clear_q  <= clear_oh_c;
         move_q   <= move_oh_c;
         dir_q    <= dir_oh_c;
      end
   end

`ifdef IOD_TRAIN_TAP_READBACK_EN
   logic [NUM_LANES*TAP_W-1:0] tap_q, tap_d;

   // Capture each lane's final step count as the sequencer leaves it.
   always_comb begin
      tap_d = tap_q;
      if ((state_q == ST_IDLE) && TRAIN_START) begin
         tap_d = '0;
      end else if (state_q == ST_NEXT) begin
         for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (lane_q == LANE_W'(i)) begin
               tap_d[i*TAP_W +: TAP_W] = step_q;
            end
         end
      end
   end

   // Tap readback register.
   always_ff @(posedge FAB_CLK) begin
      if (!SYNC_RST_N) begin
         tap_q <= '0;
      end else begin
         tap_q <= tap_d;
      end
   end

   assign TAP_POS = tap_q;
`endif

   assign TRAIN_BUSY                  = busy_q;
   assign TRAIN_DONE                  = done_q;
   assign LANE_LOCKED                 = locked_q;
   assign LANE_ERR                    = err_q;
   assign iod.DELAY_LINE_LOAD         = load_q;
   assign iod.EYE_MONITOR_CLEAR_FLAGS = clear_q;
   assign iod.DELAY_LINE_MOVE         = move_q;
   assign iod.DELAY_LINE_DIRECTION    = dir_q;

endmodule

// File: tb/tb_pf_iod_eye_train_ctrl.sv
// Bench for pf_iod_eye_train_ctrl: behavioural IOD lanes with a modelled eye, plus a per-lane
// reference of the training outcome computed directly from the early/late voting rules.
module tb_pf_iod_eye_train_ctrl;

   localparam int unsigned N         = 4;
   localparam int unsigned TAP_W     = 8;
   localparam int unsigned MAX_STEPS = 5;
   localparam int unsigned SETTLE    = 3;
   localparam int unsigned CNT_W     = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy, done;
   logic [N-1:0] locked, err;
`ifdef IOD_TRAIN_TAP_READBACK_EN
   logic [N*TAP_W-1:0] tap_pos;
`endif

   pf_iod_eye_train_ctrl_if #(.NUM_LANES(N)) iod ();

   pf_iod_eye_train_ctrl #(
      .NUM_LANES     (N),
      .TAP_W         (TAP_W),
      .MAX_STEPS     (MAX_STEPS),
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (CNT_W)
   ) dut (
      .FAB_CLK     (clk),
      .SYNC_RST_N  (rst_n),
      .TRAIN_START (start),
      .TRAIN_BUSY  (busy),
      .TRAIN_DONE  (done),
      .LANE_LOCKED (locked),
      .LANE_ERR    (err),
`ifdef IOD_TRAIN_TAP_READBACK_EN
      .TAP_POS     (tap_pos),
`endif
      .iod         (iod)
   );

   always #5 clk = ~clk;

   // Lane eye model: mode 0 clean eye centred at c, 1 no zero region (edge at c), 2 always early,
   // 3 early below c-1, both flags at c-1, late from c. oor_tap>0 saturates at |tap| >= oor_tap.
   int mode[N], centre[N], oor_tap[N];
   int tap_m[N];
   int exp_moves[N], exp_tap[N];
   logic [N-1:0] exp_locked, exp_err;
   int exp_busy;
   int move_cnt[N], load_cnt[N];
   int done_cnt, busy_cnt, viol;
   int errors = 0, checks = 0;
   logic timed_out;
   logic [1:0] fv;
   logic [N-1:0] p_load = '0, p_move = '0, p_clear = '0, p_dir = '0;

   function automatic logic [1:0] eye_flags(input int md, input int c, input int t);
      case (md)
         0:       return (t < c) ? 2'b10 : ((t > c) ? 2'b01 : 2'b00);
         1:       return (t < c) ? 2'b10 : 2'b01;
         2:       return 2'b10;
         default: return (t < c - 1) ? 2'b10 : ((t == c - 1) ? 2'b11 : 2'b01);
      endcase
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Lane flag outputs follow the modelled tap position.
   always_comb begin
      fv = 2'b00;
      for (int l = 0; l < int'(N); l++) begin
         fv = eye_flags(mode[l], centre[l], tap_m[l]);
         iod.EYE_MONITOR_EARLY[l]       = fv[1];
         iod.EYE_MONITOR_LATE[l]        = fv[0];
         iod.DELAY_LINE_OUT_OF_RANGE[l] = (oor_tap[l] != 0) && (iabs(tap_m[l]) >= oor_tap[l]);
      end
   end

   // IOD delay-line model: LOAD returns to tap 0, MOVE steps by DIRECTION.
   always @(posedge clk) begin
      for (int l = 0; l < int'(N); l++) begin
         if (iod.DELAY_LINE_LOAD[l]) tap_m[l] <= 0;
         else if (iod.DELAY_LINE_MOVE[l]) tap_m[l] <= tap_m[l] + (iod.DELAY_LINE_DIRECTION[l] ? 1 : -1);
      end
   end

   // Protocol monitor: single-cycle one-hot strobes, direction held before MOVE, no strobes outside BUSY.
   always @(negedge clk) begin
      logic [N-1:0] act;
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      for (int l = 0; l < int'(N); l++) begin
         move_cnt[l] += int'(iod.DELAY_LINE_MOVE[l]);
         load_cnt[l] += int'(iod.DELAY_LINE_LOAD[l]);
      end
      act = iod.DELAY_LINE_LOAD | iod.DELAY_LINE_MOVE | iod.EYE_MONITOR_CLEAR_FLAGS | iod.DELAY_LINE_DIRECTION;
      if ($countones(act) > 1) viol++;
      if (|(iod.DELAY_LINE_LOAD & p_load) || |(iod.DELAY_LINE_MOVE & p_move) ||
          |(iod.EYE_MONITOR_CLEAR_FLAGS & p_clear)) viol++;
      if (|(iod.DELAY_LINE_MOVE & (iod.DELAY_LINE_DIRECTION ^ p_dir))) viol++;
      if (done && busy) viol++;
      if (!busy && (act != '0)) viol++;
      p_load  = iod.DELAY_LINE_LOAD;
      p_move  = iod.DELAY_LINE_MOVE;
      p_clear = iod.EYE_MONITOR_CLEAR_FLAGS;
      p_dir   = iod.DELAY_LINE_DIRECTION;
   end

   // Reference: walk each lane's eye with the voting rules and tally moves and BUSY length.
   task automatic compute_expected();
      exp_busy   = 0;
      exp_locked = '0;
      exp_err    = '0;
      for (int l = 0; l < int'(N); l++) begin
         int t, prev, m, v;
         logic [1:0] f;
         t = 0; prev = 0; m = 0;
         for (int it = 0; it < 100; it++) begin
            f = eye_flags(mode[l], centre[l], t);
            if ((oor_tap[l] != 0) && (iabs(t) >= oor_tap[l])) begin exp_err[l] = 1'b1; break; end
            if (f == 2'b00) begin exp_locked[l] = 1'b1; break; end
            v = (f == 2'b10) ? 1 : ((f == 2'b01) ? -1 : ((prev == 0) ? 1 : prev));
            if ((prev != 0) && (v != prev)) begin exp_locked[l] = 1'b1; break; end
            if (iabs(t) == int'(MAX_STEPS)) begin exp_err[l] = 1'b1; break; end
            prev = v; t += v; m++;
         end
         exp_moves[l] = m;
         exp_tap[l]   = t;
         exp_busy += 2 + (m + 1) * (int'(SETTLE) + 2) + 2 * m;
      end
   endtask

   task automatic set_lane(input int l, input int md, input int c, input int oor);
      mode[l] = md; centre[l] = c; oor_tap[l] = oor;
   endtask

   task automatic clear_counters();
      @(posedge clk); #1;
      for (int l = 0; l < int'(N); l++) begin move_cnt[l] = 0; load_cnt[l] = 0; end
      done_cnt = 0; busy_cnt = 0; viol = 0;
   endtask

   // Stimulus: START pulse, optional extra START mid-run and on the DONE cycle, bounded wait for DONE.
   task automatic run_once(input bit pulse_mid, input bit pulse_at_done);
      bit got;
      clear_counters();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      if (pulse_mid) begin
         repeat (7) @(negedge clk);
         start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      got = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      if (got && pulse_at_done) begin
         start = 1'b1;
         @(negedge clk) start = 1'b0;
      end
      timed_out = !got;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0;
      for (int l = 0; l < int'(N); l++) set_lane(l, 0, 0, 0);
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if ({locked, err} !== '0) begin errors++; $display("FAIL reset_flags: got %h want 0", {locked, err}); end
      checks++;
      if ({iod.DELAY_LINE_LOAD, iod.DELAY_LINE_MOVE, iod.EYE_MONITOR_CLEAR_FLAGS, iod.DELAY_LINE_DIRECTION} !== '0) begin
         errors++; $display("FAIL reset_strobes: got nonzero want 0");
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_centre();
      for (int l = 0; l < int'(N); l++) set_lane(l, 0, 3, 0);
      compute_expected();
      run_once(1'b0, 1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL centre_timeout: got %b want 0", timed_out); end
      checks++; if (locked !== 4'hF) begin errors++; $display("FAIL centre_locked: got %h want f", locked); end
      checks++; if (err !== 4'h0) begin errors++; $display("FAIL centre_err: got %h want 0", err); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL centre_done: got %0d want 1", done_cnt); end
      checks++; if (busy_cnt !== exp_busy) begin errors++; $display("FAIL centre_busy: got %0d want %0d", busy_cnt, exp_busy); end
      for (int l = 0; l < int'(N); l++) begin
         checks++; if (move_cnt[l] !== 3) begin errors++; $display("FAIL centre_moves%0d: got %0d want 3", l, move_cnt[l]); end
         checks++; if (tap_m[l] !== 3) begin errors++; $display("FAIL centre_tap%0d: got %0d want 3", l, tap_m[l]); end
      end
      checks++; if (viol !== 0) begin errors++; $display("FAIL centre_protocol: got %0d want 0", viol); end
   endtask

   task automatic test_mixed();
      set_lane(0, 0, 4, 1);   // saturates on the second sample after one move
      set_lane(1, 1, -2, 0);  // late-only walk down until the flip
      set_lane(2, 2, 0, 0);   // early forever: runs out of steps
      set_lane(3, 3, 2, 0);   // both-flags tap repeats INC, then flips
      compute_expected();
      run_once(1'b0, 1'b0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL mixed_timeout: got %b want 0", timed_out); end
      checks++; if (locked !== exp_locked) begin errors++; $display("FAIL mixed_locked: got %h want %h", locked, exp_locked); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL mixed_err: got %h want %h", err, exp_err); end
      checks++; if ((locked & err) !== '0) begin errors++; $display("FAIL mixed_exclusive: got %h want 0", locked & err); end
      checks++; if (move_cnt[2] !== int'(MAX_STEPS)) begin errors++; $display("FAIL mixed_maxsteps: got %0d want %0d", move_cnt[2], MAX_STEPS); end
      checks++; if (move_cnt[0] !== 1) begin errors++; $display("FAIL mixed_oor_moves: got %0d want 1", move_cnt[0]); end
      for (int l = 0; l < int'(N); l++) begin
         checks++; if (move_cnt[l] !== exp_moves[l]) begin errors++; $display("FAIL mixed_moves%0d: got %0d want %0d", l, move_cnt[l], exp_moves[l]); end
         checks++; if (tap_m[l] !== exp_tap[l]) begin errors++; $display("FAIL mixed_tap%0d: got %0d want %0d", l, tap_m[l], exp_tap[l]); end
         checks++; if (load_cnt[l] !== 1) begin errors++; $display("FAIL mixed_load%0d: got %0d want 1", l, load_cnt[l]); end
`ifdef IOD_TRAIN_TAP_READBACK_EN
         checks++;
         if (int'($signed(tap_pos[l*TAP_W +: TAP_W])) !== exp_tap[l]) begin
            errors++; $display("FAIL mixed_tappos%0d: got %0d want %0d", l, $signed(tap_pos[l*TAP_W +: TAP_W]), exp_tap[l]);
         end
`endif
      end
      checks++; if (busy_cnt !== exp_busy) begin errors++; $display("FAIL mixed_busy: got %0d want %0d", busy_cnt, exp_busy); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL mixed_protocol: got %0d want 0", viol); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int l = 0; l < int'(N); l++) begin
            set_lane(l, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)) - 6,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
         end
         compute_expected();
         run_once(1'b0, 1'b0);
         checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: got %b want 0", r, timed_out); end
         checks++; if (locked !== exp_locked) begin errors++; $display("FAIL rand%0d_locked: got %h want %h", r, locked, exp_locked); end
         checks++; if (err !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %h want %h", r, err, exp_err); end
         for (int l = 0; l < int'(N); l++) begin
            checks++;
            if ((move_cnt[l] !== exp_moves[l]) || (tap_m[l] !== exp_tap[l])) begin
               errors++; $display("FAIL rand%0d_lane%0d: got moves=%0d tap=%0d want moves=%0d tap=%0d",
                                  r, l, move_cnt[l], tap_m[l], exp_moves[l], exp_tap[l]);
            end
         end
         checks++; if (busy_cnt !== exp_busy) begin errors++; $display("FAIL rand%0d_busy: got %0d want %0d", r, busy_cnt, exp_busy); end
         checks++; if ((done_cnt !== 1) || (viol !== 0)) begin errors++; $display("FAIL rand%0d_proto: got done=%0d viol=%0d want 1 0", r, done_cnt, viol); end
      end
   endtask

   task automatic test_start_busy();
      for (int l = 0; l < int'(N); l++) set_lane(l, 0, int'($urandom_range(0, 8)) - 4, 0);
      compute_expected();
      run_once(1'b1, 1'b1);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL sbusy_timeout: got %b want 0", timed_out); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sbusy_done: got %0d want 1", done_cnt); end
      checks++; if (busy_cnt !== exp_busy) begin errors++; $display("FAIL sbusy_len: got %0d want %0d", busy_cnt, exp_busy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sbusy_after_done: got %b want 0", busy); end
      checks++; if (locked !== exp_locked) begin errors++; $display("FAIL sbusy_locked: got %h want %h", locked, exp_locked); end
   endtask

   task automatic test_reset_mid();
      bit got;
      set_lane(0, 0, 0, 0);
      set_lane(1, 2, 0, 0);
      set_lane(2, 0, 1, 0);
      set_lane(3, 0, 1, 0);
      clear_counters();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (iod.EYE_MONITOR_CLEAR_FLAGS[1]) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rmid_reach_lane1: got %b want 1", got); end
      @(negedge clk);
      checks++; if (locked[0] !== 1'b1) begin errors++; $display("FAIL rmid_lane0_locked: got %b want 1", locked[0]); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rmid_busy_done: got %b want 00", {busy, done}); end
      checks++; if ({locked, err} !== '0) begin errors++; $display("FAIL rmid_flags: got %h want 0", {locked, err}); end
      checks++;
      if ({iod.DELAY_LINE_LOAD, iod.DELAY_LINE_MOVE, iod.EYE_MONITOR_CLEAR_FLAGS, iod.DELAY_LINE_DIRECTION} !== '0) begin
         errors++; $display("FAIL rmid_strobes: got nonzero want 0");
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", busy); end
      compute_expected();
      run_once(1'b0, 1'b0);
      checks++; if ((locked !== exp_locked) || (err !== exp_err)) begin
         errors++; $display("FAIL rmid_rerun: got %h/%h want %h/%h", locked, err, exp_locked, exp_err);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_centre();
      test_mixed();
      test_random();
      test_start_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
